ram_bist_ctrl: RTL and testbench

Built-in self-test initiator for one port of true_dual_port_ram (or any synchronous RAM with the same port shape). On start it writes a deterministic address-derived pattern to every location, reads every location back and compares against the expected pattern, accounting for the RAM's read latency. It reports pass/fail, a saturating error count and the first failing address, and sits beside the RAM in the ram/pll test top level.

---
 rtl/ram_bist_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march-style write/read/compare self-test initiator for one
// synchronous RAM port, with read-latency-aligned compare pipeline.
//
// Parameters:
//   DATA_WIDTH  RAM data width
//   ADDR_WIDTH  RAM address width (DEPTH = 2**ADDR_WIDTH)
//   RD_LAT      RAM read latency, 1 or 2 clocks
//   SEED        constant XORed into the address-derived pattern
//
// Ports:
//   clk_i        clock for controller and RAM port
//   rst_i        synchronous active-high reset
//   start_i      one-cycle start request, sampled only when idle
//   busy_o       test in progress
//   done_o       one-cycle completion pulse
//   pass_o       last completed test had zero mismatches
//   err_cnt_o    saturating mismatch count
//   fail_addr_o  address of the first mismatch
//   ram_we_o     RAM write enable
//   ram_addr_o   RAM address
//   ram_din_o    RAM write data
//   ram_dout_i   RAM read data
//
// Build option: define RAM_BIST_INV_PASS_EN to add a second
// write/read/drain sequence using the inverted pattern.

module ram_bist_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    RD_LAT     = 1,
  parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(8'hA5)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [15:0]           err_cnt_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_din_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_i
);

  if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
    $error("ram_bist_ctrl: RD_LAT must be 1 or 2");
  end

  // Number of address bits that reach the pattern.
  localparam int EXT_W =
    (ADDR_WIDTH < DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;

  localparam logic [0:0] DRN_LAST = 1'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [0:0]            drn_q, drn_d;
  logic                  phase_q, phase_d;
  logic [15:0]           err_q, err_d;
  logic [ADDR_WIDTH-1:0] fail_q, fail_d;
  logic                  pass_q, pass_d;

  // Compare pipeline: one entry per outstanding read.
  logic                  pv_q [RD_LAT];
  logic [ADDR_WIDTH-1:0] pa_q [RD_LAT];
  logic [DATA_WIDTH-1:0] pd_q [RD_LAT];

  logic                  addr_last;
  logic [DATA_WIDTH-1:0] exp_pat;
  logic                  cmp_vld;
  logic                  mism;

  function automatic logic [DATA_WIDTH-1:0] pat(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [DATA_WIDTH-1:0] e;
    e = '0;
    e[EXT_W-1:0] = a[EXT_W-1:0];
    return e ^ SEED;
  endfunction

  assign addr_last = (addr_q == '1);

  // Second pass (if built) uses the bitwise-inverted pattern.
  assign exp_pat = pat(addr_q) ^ {DATA_WIDTH{phase_q}};

  // ---------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      drn_q   <= '0;
      phase_q <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drn_q   <= drn_d;
      phase_q <= phase_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drn_d   = drn_q;
    phase_d = phase_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_WRITE;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        if (addr_last) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        addr_d = addr_q + 1'b1;
        if (addr_last) begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end
      end
      S_DRAIN: begin
        drn_d = drn_q + 1'b1;
        if (drn_q == DRN_LAST) begin
          drn_d = '0;
`ifdef RAM_BIST_INV_PASS_EN
          if (!phase_q) begin
            state_d = S_WRITE;
            phase_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Compare and result bookkeeping
  // ---------------------------------------------------------------
  assign cmp_vld = pv_q[RD_LAT-1] &&
                   ((state_q == S_READ) || (state_q == S_DRAIN));
  assign mism    = cmp_vld && (ram_dout_i != pd_q[RD_LAT-1]);

  always_comb begin
    err_d  = err_q;
    fail_d = fail_q;
    pass_d = pass_q;
    if ((state_q == S_IDLE) && start_i) begin
      err_d  = '0;
      fail_d = '0;
      pass_d = 1'b0;
    end else if (mism) begin
      if (err_q != '1) begin
        err_d = err_q + 16'd1;
      end
      // A zero count means no earlier mismatch in this test.
      if (err_q == '0) begin
        fail_d = pa_q[RD_LAT-1];
      end
    end
    // Verdict includes the compare happening in the last drain cycle.
    if ((state_q == S_DRAIN) && (state_d == S_DONE)) begin
      pass_d = (err_d == '0);
    end
  end

  // Read tag pipeline, aligned to the RAM read latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= '0;
        pd_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= (state_q == S_READ);
      pa_q[0] <= addr_q;
      pd_q[0] <= exp_pat;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------
  always_comb begin
    busy_o      = (state_q == S_WRITE) ||
                  (state_q == S_READ)  ||
                  (state_q == S_DRAIN);
    done_o      = (state_q == S_DONE);
    pass_o      = pass_q;
    err_cnt_o   = err_q;
    fail_addr_o = fail_q;
    ram_we_o    = (state_q == S_WRITE);
    ram_addr_o  = addr_q;
    ram_din_o   = (state_q == S_WRITE) ? exp_pat : '0;
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: directed bench for ram_bist_ctrl with RAM models at
// read latency 1 and 2 and injectable read faults.

module tb_ram_bist_ctrl;

`ifdef RAM_BIST_INV_PASS_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  logic       clk;
  logic       rst;
  int         fmode;
  int         n_chk;
  int         n_err;

  logic       start_s [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       pass_s  [2];
  logic [15:0] err_s  [2];
  logic [3:0] fail_s  [2];
  logic       we_s    [2];
  logic [3:0] addr_s  [2];
  logic [7:0] din_s   [2];
  logic [7:0] dout_s  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rd_fault(
    input logic [7:0] d,
    input logic [3:0] a
  );
    logic [7:0] r;
    r = d;
    if (fmode == 1 && (a == 4'd4 || a == 4'd9)) r[0] = 1'b1;
    if (fmode == 2) r = 8'h00;
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [7:0] mem [16];
    logic [7:0] q1;
    logic [7:0] q2;

    ram_bist_ctrl #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(4),
      .RD_LAT    (g + 1),
      .SEED      (8'hA5)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start_s[g]),
      .busy_o     (busy_s[g]),
      .done_o     (done_s[g]),
      .pass_o     (pass_s[g]),
      .err_cnt_o  (err_s[g]),
      .fail_addr_o(fail_s[g]),
      .ram_we_o   (we_s[g]),
      .ram_addr_o (addr_s[g]),
      .ram_din_o  (din_s[g]),
      .ram_dout_i (dout_s[g])
    );

    always @(posedge clk) begin
      if (we_s[g]) mem[addr_s[g]] <= din_s[g];
      q1 <= rd_fault(mem[addr_s[g]], addr_s[g]);
      q2 <= q1;
    end

    if (g == 0) begin : g_l1
      assign dout_s[g] = q1;
    end else begin : g_l2
      assign dout_s[g] = q2;
    end
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulses start, optionally re-pulses it at cycle 'extra', and
  // returns at the negedge where done is seen.
  task automatic run_test(
    input int i,
    input int extra,
    input int exp_lat,
    input int exp_busy,
    input int exp_errc,
    input int exp_fail,
    input int exp_pass
  );
    int cnt;
    int nb;
    bit seen;
    cnt  = 0;
    nb   = 0;
    seen = 0;
    @(negedge clk);
    start_s[i] = 1'b1;
    while (!seen && cnt < 200) begin
      @(negedge clk);
      cnt++;
      start_s[i] = (cnt == extra);
      if (busy_s[i]) nb++;
      if (cnt == 1) begin
        check("start_busy", 32'(busy_s[i]), 1);
        check("start_pass_clr", 32'(pass_s[i]), 0);
        check("start_err_clr", 32'(err_s[i]), 0);
        check("wr0_we", 32'(we_s[i]), 1);
        check("wr0_addr", 32'(addr_s[i]), 0);
        check("wr0_din", 32'(din_s[i]), 32'hA5);
      end
      if (cnt == 16) begin
        check("wr15_addr", 32'(addr_s[i]), 15);
        check("wr15_din", 32'(din_s[i]), 32'hAA);
      end
      if (cnt == 17) begin
        check("rd0_we", 32'(we_s[i]), 0);
        check("rd0_din", 32'(din_s[i]), 0);
      end
      if (done_s[i]) seen = 1;
    end
    start_s[i] = 1'b0;
    check("done_lat", cnt, exp_lat);
    check("busy_len", nb, exp_busy);
    check("done_busy", 32'(busy_s[i]), 0);
    check("err_cnt", 32'(err_s[i]), exp_errc);
    check("fail_addr", 32'(fail_s[i]), exp_fail);
    check("pass", 32'(pass_s[i]), exp_pass);
  endtask

  initial begin
    int nd;
    n_chk = 0;
    n_err = 0;
    fmode = 0;
    rst   = 1'b1;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_busy", 32'(busy_s[0]), 0);
    check("rst_done", 32'(done_s[0]), 0);
    check("rst_pass", 32'(pass_s[0]), 0);
    check("rst_err", 32'(err_s[0]), 0);
    check("rst_fail", 32'(fail_s[0]), 0);
    check("rst_we", 32'(we_s[0]), 0);
    check("rst_addr", 32'(addr_s[0]), 0);
    check("rst_din", 32'(din_s[0]), 0);

    // Fault-free, latency 1.
    run_test(0, -1, NP * 33 + 1, NP * 33, 0, 0, 1);

    // Start in the done cycle must be ignored.
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy_s[0]) nd++;
    end
    check("start_at_done", nd, 0);
    check("pass_hold", 32'(pass_s[0]), 1);

    // Fault-free, latency 2.
    run_test(1, -1, NP * 34 + 1, NP * 34, 0, 0, 1);

    // Bit0 stuck-at-1 at 4 and 9.
    fmode = 1;
    run_test(0, -1, NP * 33 + 1, NP * 33, NP, 9, 0);

    // All bits stuck-at-0.
    fmode = 2;
    run_test(0, -1, NP * 33 + 1, NP * 33, NP * 16, 0, 0);
    run_test(1, -1, NP * 34 + 1, NP * 34, NP * 16, 0, 0);

    // Start re-pulsed during WRITE is ignored.
    fmode = 0;
    run_test(0, 5, NP * 33 + 1, NP * 33, 0, 0, 1);

    // Reset in READ cycle 3, with errors already accumulating.
    fmode = 2;
    @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_rst_err_nz", 32'(err_s[0] != 0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy_s[0]), 0);
    check("mid_rst_we", 32'(we_s[0]), 0);
    check("mid_rst_err", 32'(err_s[0]), 0);
    check("mid_rst_done", 32'(done_s[0]), 0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_s[0] || busy_s[0]) nd++;
    end
    check("no_done_after_rst", nd, 0);

    fmode = 0;
    run_test(0, -1, NP * 33 + 1, NP * 33, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
